mips_cache_writebuffer_coalesce: RTL and testbench

- Parametrised write buffer between the data cache and the Avalon master port.
- Queues cache write-throughs in a DEPTH-entry FIFO and drains them to memory with an Avalon-legal handshake.
- Provides a combinational read-lookup port so read misses see pending data (read-after-write forwarding).
- Optionally coalesces writes to the same word into an already pending entry.

---
 rtl/mips_cache_writebuffer_coalesce.sv | 145 ++++++++++++++
 tb/tb_mips_cache_writebuffer_coalesce.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cache_writebuffer_coalesce.sv
// Write buffer between the data cache and the Avalon master port: FIFO of pending writes,
// Avalon drain FSM and read-after-write lookup. Define WB_COALESCE_EN to merge same-word writes.
module mips_cache_writebuffer_coalesce #(
  parameter int DEPTH_BITS = 3,
  parameter int AF_MARGIN  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_addr,
  input  logic [31:0]           in_writedata,
  input  logic [3:0]            in_byteenable,
  input  logic [31:0]           lk_addr,
  output logic                  lk_hit,
  output logic [31:0]           lk_data,
  output logic [3:0]            lk_byteenable,
  input  logic                  active,
  output logic [31:0]           avm_address,
  output logic                  avm_write,
  output logic [31:0]           avm_writedata,
  output logic [3:0]            avm_byteenable,
  input  logic                  avm_waitrequest,
  output logic [DEPTH_BITS:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full
);
  localparam int DEPTH    = 2**DEPTH_BITS;
  localparam int AF_LEVEL = DEPTH - AF_MARGIN;

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  state_t                state, state_nxt;
  logic [DEPTH_BITS-1:0] head, tail, idx;
  logic [DEPTH_BITS:0]   count_nxt;
  logic [29:0]           ent_addr [DEPTH];
  logic [31:0]           ent_data [DEPTH];
  logic [3:0]            ent_be   [DEPTH];
  logic                  pop, alloc, merge, merge_ok;
  logic                  unused_lsbs;

  assign unused_lsbs = ^{in_addr[1:0], lk_addr[1:0]};

  assign full        = (count == (DEPTH_BITS+1)'(DEPTH));
  assign empty       = (count == '0);
  assign almost_full = (int'(count) >= AF_LEVEL);

`ifdef WB_COALESCE_EN
  logic [DEPTH_BITS-1:0] newest;
  assign newest = tail - 1'b1;
  // The head is locked while it is on the bus; only a newer entry may absorb a write.
  assign merge_ok = !empty && !(state == S_WRITE && newest == head) &&
                    (ent_addr[newest] == in_addr[31:2]);
`else
  assign merge_ok = 1'b0;
`endif

  assign in_ready = !full || merge_ok;
  assign merge    = in_valid && merge_ok;
  assign alloc    = in_valid && in_ready && !merge;
  assign pop      = (state == S_WRITE) && !avm_waitrequest;

  always_comb begin
    count_nxt = count;
    if (alloc && !pop)      count_nxt = count + 1'b1;
    else if (!alloc && pop) count_nxt = count - 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (active && (!empty || alloc)) state_nxt = S_WRITE;
      S_WRITE: if (pop) state_nxt = (active && count_nxt != '0) ? S_WRITE : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    avm_write      = 1'b0;
    avm_address    = '0;
    avm_writedata  = '0;
    avm_byteenable = '0;
    if (state == S_WRITE) begin
      avm_write      = 1'b1;
      avm_address    = {ent_addr[head], 2'b00};
      avm_writedata  = ent_data[head];
      avm_byteenable = ent_be[head];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (alloc) tail <= tail + 1'b1;
      if (pop)   head <= head + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
        ent_be[i]   <= '0;
      end
    end else begin
      if (alloc) begin
        ent_addr[tail] <= in_addr[31:2];
        ent_data[tail] <= in_writedata;
        ent_be[tail]   <= in_byteenable;
      end
`ifdef WB_COALESCE_EN
      if (merge) begin
        for (int b = 0; b < 4; b++)
          if (in_byteenable[b]) ent_data[newest][8*b +: 8] <= in_writedata[8*b +: 8];
        ent_be[newest] <= ent_be[newest] | in_byteenable;
      end
`endif
    end
  end

  // Walk oldest to newest so later entries overwrite earlier lanes.
  always_comb begin
    lk_hit        = 1'b0;
    lk_data       = '0;
    lk_byteenable = '0;
    idx           = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + i[DEPTH_BITS-1:0];
      if (((DEPTH_BITS+1)'(i) < count) && (ent_addr[idx] == lk_addr[31:2])) begin
        lk_hit        = 1'b1;
        lk_byteenable = lk_byteenable | ent_be[idx];
        for (int b = 0; b < 4; b++)
          if (ent_be[idx][b]) lk_data[8*b +: 8] = ent_data[idx][8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_mips_cache_writebuffer_coalesce.sv
// Directed bench for the cache write buffer: table of per-cycle vectors plus hand-written
// sequences for full/drain, waitrequest hold, locked-head coalescing and async reset.
module tb_mips_cache_writebuffer_coalesce;
`ifdef WB_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_addr, in_writedata;
  logic [3:0]  in_byteenable;
  logic [31:0] lk_addr, lk_data;
  logic        lk_hit;
  logic [3:0]  lk_byteenable;
  logic        active;
  logic [31:0] avm_address, avm_writedata;
  logic        avm_write, avm_waitrequest;
  logic [3:0]  avm_byteenable;
  logic [3:0]  count;
  logic        full, empty, almost_full;

  int total = 0;
  int bad   = 0;

  mips_cache_writebuffer_coalesce #(.DEPTH_BITS(3), .AF_MARGIN(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_writedata(in_writedata), .in_byteenable(in_byteenable),
    .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_data(lk_data), .lk_byteenable(lk_byteenable),
    .active(active),
    .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] a, d;
    logic [3:0]  be;
    logic        act, wr;
    logic [31:0] lk;
    logic [31:0] cnt;
    logic        rdy, aw;
    logic [31:0] aa, ad;
    logic [3:0]  abe;
    logic        hit;
    logic [3:0]  lbe;
    logic [31:0] ld;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act_v, exp_v);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic act, input logic wr);
    in_valid = v; in_addr = a; in_writedata = d; in_byteenable = be;
    active = act; avm_waitrequest = wr;
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk); #1;
      if (count == 4'd0 && !avm_write) begin
        done = 1'b1;
        break;
      end
    end
    check(name, {31'b0, done}, 32'd1);
  endtask

  logic [31:0] c2, c3, d10;
  logic [3:0]  b10;

  initial begin
    c2  = COAL ? 32'd1 : 32'd2;
    c3  = COAL ? 32'd2 : 32'd3;
    d10 = COAL ? 32'h11BB3344 : 32'h11223344;
    b10 = COAL ? 4'h7 : 4'h3;
    //          v  addr       data          be    act wr lk        | cnt  rdy aw addr       data          be    hit lbe   ldata
    tbl[0]  = '{1, 32'h100, 32'hDEADBEEF, 4'hF, 1, 0, 32'h100,  0,   1,  0, 32'h0,    32'h0,        4'h0, 0,  4'h0, 32'h0};
    tbl[1]  = '{0, 32'h0,   32'h0,        4'h0, 1, 0, 32'h100,  1,   1,  1, 32'h100,  32'hDEADBEEF, 4'hF, 1,  4'hF, 32'hDEADBEEF};
    tbl[2]  = '{0, 32'h0,   32'h0,        4'h0, 0, 0, 32'h100,  0,   1,  0, 32'h0,    32'h0,        4'h0, 0,  4'h0, 32'h0};
    tbl[3]  = '{1, 32'h200, 32'h11223344, 4'h3, 0, 0, 32'h203,  0,   1,  0, 32'h0,    32'h0,        4'h0, 0,  4'h0, 32'h0};
    tbl[4]  = '{1, 32'h200, 32'hAABBCCDD, 4'h4, 0, 0, 32'h203,  1,   1,  0, 32'h0,    32'h0,        4'h0, 1,  4'h3, 32'h00003344};
    tbl[5]  = '{0, 32'h0,   32'h0,        4'h0, 0, 0, 32'h203,  c2,  1,  0, 32'h0,    32'h0,        4'h0, 1,  4'h7, 32'h00BB3344};
    tbl[6]  = '{0, 32'h0,   32'h0,        4'h0, 0, 0, 32'h204,  c2,  1,  0, 32'h0,    32'h0,        4'h0, 0,  4'h0, 32'h0};
    tbl[7]  = '{1, 32'h208, 32'hCAFEF00D, 4'h0, 0, 0, 32'h200,  c2,  1,  0, 32'h0,    32'h0,        4'h0, 1,  4'h7, 32'h00BB3344};
    tbl[8]  = '{0, 32'h0,   32'h0,        4'h0, 0, 0, 32'h208,  c3,  1,  0, 32'h0,    32'h0,        4'h0, 1,  4'h0, 32'h0};
    tbl[9]  = '{0, 32'h0,   32'h0,        4'h0, 1, 1, 32'h200,  c3,  1,  0, 32'h0,    32'h0,        4'h0, 1,  4'h7, 32'h00BB3344};
    tbl[10] = '{0, 32'h0,   32'h0,        4'h0, 1, 1, 32'h200,  c3,  1,  1, 32'h200,  d10,          b10,  1,  4'h7, 32'h00BB3344};
    tbl[11] = '{0, 32'h0,   32'h0,        4'h0, 1, 0, 32'h200,  c3,  1,  1, 32'h200,  d10,          b10,  1,  4'h7, 32'h00BB3344};

    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    lk_addr = 32'h0;
    #1;
    check("rst_count", {28'b0, count}, 32'd0);
    check("rst_empty", {31'b0, empty}, 32'd1);
    check("rst_full", {31'b0, full}, 32'd0);
    check("rst_af", {31'b0, almost_full}, 32'd0);
    check("rst_ready", {31'b0, in_ready}, 32'd1);
    check("rst_avm_write", {31'b0, avm_write}, 32'd0);
    check("rst_lk_hit", {31'b0, lk_hit}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].be, tbl[i].act, tbl[i].wr);
      lk_addr = tbl[i].lk;
      #1;
      check($sformatf("r%0d_count", i), {28'b0, count}, tbl[i].cnt);
      check($sformatf("r%0d_ready", i), {31'b0, in_ready}, {31'b0, tbl[i].rdy});
      check($sformatf("r%0d_avm_write", i), {31'b0, avm_write}, {31'b0, tbl[i].aw});
      check($sformatf("r%0d_avm_addr", i), avm_address, tbl[i].aa);
      check($sformatf("r%0d_avm_data", i), avm_writedata, tbl[i].ad);
      check($sformatf("r%0d_avm_be", i), {28'b0, avm_byteenable}, {28'b0, tbl[i].abe});
      check($sformatf("r%0d_lk_hit", i), {31'b0, lk_hit}, {31'b0, tbl[i].hit});
      check($sformatf("r%0d_lk_be", i), {28'b0, lk_byteenable}, {28'b0, tbl[i].lbe});
      check($sformatf("r%0d_lk_data", i), lk_data, tbl[i].ld);
    end
    drain("tbl_drain");
    lk_addr = 32'h200;
    #1 check("tbl_lk_after_drain", {31'b0, lk_hit}, 32'd0);

    // Fill to full with drain disabled, then drain back-to-back.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(1'b1, 32'h1000 + 32'(4*i), 32'hA0000000 + 32'(i), 4'hF, 1'b0, 1'b0);
      #1;
      check($sformatf("fill%0d_count", i), {28'b0, count}, 32'(i));
      check($sformatf("fill%0d_af", i), {31'b0, almost_full}, {31'b0, (i >= 7)});
      check($sformatf("fill%0d_ready", i), {31'b0, in_ready}, 32'd1);
    end
    @(negedge clk);
    drive(1'b1, 32'h2000, 32'h99999999, 4'hF, 1'b0, 1'b0);
    #1;
    check("full_count", {28'b0, count}, 32'd8);
    check("full_flag", {31'b0, full}, 32'd1);
    check("full_ready", {31'b0, in_ready}, 32'd0);
    check("full_af", {31'b0, almost_full}, 32'd1);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);
    #1;
    check("ninth_rejected", {28'b0, count}, 32'd8);
    check("idle_before_drain", {31'b0, avm_write}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      check($sformatf("b2b%0d_write", i), {31'b0, avm_write}, 32'd1);
      check($sformatf("b2b%0d_addr", i), avm_address, 32'h1000 + 32'(4*i));
      check($sformatf("b2b%0d_data", i), avm_writedata, 32'hA0000000 + 32'(i));
    end
    @(negedge clk); #1;
    check("b2b_end_write", {31'b0, avm_write}, 32'd0);
    check("b2b_end_empty", {31'b0, empty}, 32'd1);

    // Waitrequest hold with active dropping mid-stall.
    @(negedge clk);
    drive(1'b1, 32'h400, 32'h12345678, 4'hF, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(1'b0, 32'h0, 32'h0, 4'h0, (k < 1), 1'b1);
      #1;
      check($sformatf("hold%0d_write", k), {31'b0, avm_write}, 32'd1);
      check($sformatf("hold%0d_addr", k), avm_address, 32'h400);
      check($sformatf("hold%0d_data", k), avm_writedata, 32'h12345678);
      check($sformatf("hold%0d_be", k), {28'b0, avm_byteenable}, 32'hF);
      check($sformatf("hold%0d_count", k), {28'b0, count}, 32'd1);
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    #1 check("hold_release_write", {31'b0, avm_write}, 32'd1);
    @(negedge clk); #1;
    check("hold_after_write", {31'b0, avm_write}, 32'd0);
    check("hold_after_count", {28'b0, count}, 32'd0);
    check("hold_after_addr", avm_address, 32'h0);

`ifdef WB_COALESCE_EN
    // A write matching only the locked head must allocate a new entry.
    @(negedge clk);
    drive(1'b1, 32'h300, 32'h00000001, 4'hF, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b1, 32'h300, 32'h00000002, 4'hF, 1'b1, 1'b1);
    #1 check("lock_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1);
    lk_addr = 32'h300;
    #1;
    check("lock_count", {28'b0, count}, 32'd2);
    check("lock_head_data", avm_writedata, 32'h00000001);
    check("lock_head_addr", avm_address, 32'h300);
    check("lock_lk_newest", lk_data, 32'h00000002);
    drain("lock_drain");
`endif

    // Async reset while a write is on the bus with three entries pending.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 32'h500 + 32'(4*i), 32'hB0000000 + 32'(i), 4'hF, 1'b0, 1'b0);
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1);
    lk_addr = 32'h500;
    @(negedge clk); #1;
    check("pre_rst_write", {31'b0, avm_write}, 32'd1);
    check("pre_rst_count", {28'b0, count}, 32'd3);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_write", {31'b0, avm_write}, 32'd0);
    check("mid_rst_addr", avm_address, 32'h0);
    check("mid_rst_data", avm_writedata, 32'h0);
    check("mid_rst_count", {28'b0, count}, 32'd0);
    check("mid_rst_empty", {31'b0, empty}, 32'd1);
    check("mid_rst_lk_hit", {31'b0, lk_hit}, 32'd0);
    check("mid_rst_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    @(negedge clk); #1;
    check("post_rst_write", {31'b0, avm_write}, 32'd0);
    check("post_rst_count", {28'b0, count}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
